// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the multi-channel debouncer.
// Widths are clamped to at least one bit so degenerate parameters still elaborate.
package debounce_pkg;

  localparam logic PRESSED  = 1'b1;
  localparam logic RELEASED = 1'b0;

  function automatic int safe_clog2(input int value);
    int w;
    w = $clog2(value);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

  function automatic int prescale_width(input int sample_div);
    return safe_clog2(sample_div);
  endfunction

  function automatic int hold_width(input int hold_ticks);
    return safe_clog2(hold_ticks + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced button: 2-flop synchroniser, sample shift register,
// registered level with press/release pulses and a long-press hold counter.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int HOLD_TICKS = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_tick_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic long_pulse_o
);

  localparam logic RAW_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic             sync1_q;
  logic             sync2_q;
  logic             sample_n;
  logic [DEPTH-1:0] shift_q;
  logic [DEPTH-1:0] shift_d;
  logic             level_q;
  logic             level_d;
  logic             press_q;
  logic             press_d;
  logic             release_q;
  logic             release_d;

  // Normalise polarity right after the synchroniser so everything downstream is pressed = 1.
  assign sample_n = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    shift_d = shift_q;
    if (sample_tick_i) begin
      shift_d = {shift_q[DEPTH-2:0], sample_n};
    end
  end

  always_comb begin
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if ((&shift_q) && (level_q == RELEASED)) begin
      level_d = PRESSED;
      press_d = 1'b1;
    end else if ((~|shift_q) && (level_q == PRESSED)) begin
      level_d   = RELEASED;
      release_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      level_q   <= RELEASED;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o         = level_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;

  generate
    if (HOLD_TICKS > 0) begin : g_hold
      localparam int HW = hold_width(HOLD_TICKS);
      localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS);
      localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

      logic [HW-1:0] hold_q;
      logic [HW-1:0] hold_d;
      logic          long_q;
      logic          long_d;

      // Saturating at HOLD_MAX is what limits long_pulse to once per press.
      always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (level_q == RELEASED) begin
          hold_d = '0;
        end else if (sample_tick_i && (hold_q != HOLD_MAX)) begin
          hold_d = hold_q + 1'b1;
          long_d = (hold_q == HOLD_LAST);
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          hold_q <= '0;
          long_q <= 1'b0;
        end else begin
          hold_q <= hold_d;
          long_q <= long_d;
        end
      end

      assign long_pulse_o = long_q;
    end else begin : g_no_hold
      assign long_pulse_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/debounce_array.sv
// Multi-channel push-button debouncer: one shared sample prescaler feeding
// N_CH independent debounce_channel instances.
module debounce_array
  import debounce_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int SAMPLE_DIV = 500000,
  parameter int DEPTH      = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int HOLD_TICKS = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic            sample_tick
);

  localparam int CNT_W = prescale_width(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             tick_q;
  logic             tick_d;

  // Tick is registered on the wrap, so the first one appears SAMPLE_DIV cycles after reset.
  always_comb begin
    count_d = count_q + 1'b1;
    tick_d  = 1'b0;
    if (count_q == CNT_LAST) begin
      count_d = '0;
      tick_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign sample_tick = tick_q;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      debounce_channel #(
        .DEPTH      (DEPTH),
        .ACTIVE_LOW (ACTIVE_LOW),
        .HOLD_TICKS (HOLD_TICKS)
      ) u_channel (
        .clk             (clk),
        .rst             (rst),
        .sample_tick_i   (tick_q),
        .btn_i           (btn_in[gi]),
        .level_o         (level_out[gi]),
        .press_pulse_o   (press_pulse[gi]),
        .release_pulse_o (release_pulse[gi]),
        .long_pulse_o    (long_pulse[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_debounce_array.sv
// Bench for debounce_array: scenario table, re-qualification after reset,
// and random button activity checked every cycle against a run-length model.
module tb_debounce_array;

  localparam int N_CH = 2;
  localparam int SD   = 4;
  localparam int D    = 4;
  localparam int AL   = 1;
  localparam int H    = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] btn_in = 2'b11;
  logic [N_CH-1:0] level_out;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] long_pulse;
  logic            sample_tick;

  debounce_array #(
    .N_CH       (N_CH),
    .SAMPLE_DIV (SD),
    .DEPTH      (D),
    .ACTIVE_LOW (AL),
    .HOLD_TICKS (H)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_in        (btn_in),
    .level_out     (level_out),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .sample_tick   (sample_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: samples are tracked as trailing run lengths of pressed/released values.
  int         e;
  logic [1:0] h1, h2;
  int         prun [2];
  int         rrun [2];
  int         hold [2];
  logic [1:0] m_lvl, m_press, m_rel, m_long;
  logic       m_tick;

  int cnt_p [2];
  int cnt_r [2];
  int cnt_l [2];
  int cnt_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic [1:0] b);
    logic tick_before;
    logic was;
    if (r) begin
      e = 0; h1 = 2'b11; h2 = 2'b11; m_tick = 1'b0;
      m_lvl = '0; m_press = '0; m_rel = '0; m_long = '0;
      for (int ch = 0; ch < 2; ch++) begin
        prun[ch] = 0; rrun[ch] = D; hold[ch] = 0;
      end
    end else begin
      e++;
      tick_before = m_tick;
      for (int ch = 0; ch < 2; ch++) begin
        was = m_lvl[ch];
        m_press[ch] = 1'b0; m_rel[ch] = 1'b0; m_long[ch] = 1'b0;
        if (prun[ch] >= D && !was) begin
          m_lvl[ch] = 1'b1; m_press[ch] = 1'b1;
        end else if (rrun[ch] >= D && was) begin
          m_lvl[ch] = 1'b0; m_rel[ch] = 1'b1;
        end
        if (!was) hold[ch] = 0;
        else if (tick_before && hold[ch] < H) begin
          hold[ch]++;
          if (hold[ch] == H) m_long[ch] = 1'b1;
        end
        if (tick_before) begin
          if (h2[ch] == 1'b0) begin prun[ch]++; rrun[ch] = 0; end
          else begin rrun[ch]++; prun[ch] = 0; end
        end
      end
      m_tick = ((e % SD) == 0);
      h2 = h1; h1 = b;
    end
  endtask

  task automatic step(input logic r, input logic [1:0] b);
    @(negedge clk);
    rst = r; btn_in = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    check("cycle", {23'd0, level_out, press_pulse, release_pulse, long_pulse, sample_tick},
                   {23'd0, m_lvl, m_press, m_rel, m_long, m_tick});
    for (int ch = 0; ch < 2; ch++) begin
      cnt_p[ch] += int'(press_pulse[ch]);
      cnt_r[ch] += int'(release_pulse[ch]);
      cnt_l[ch] += int'(long_pulse[ch]);
    end
    cnt_t += int'(sample_tick);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] btn;
    int         cycles;
    logic [1:0] lvl;
    int p0, p1, r0, r1, l0, l1, ticks;
  } vec_t;

  vec_t vecs [10];

  initial begin
    #500000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, first_tick, len;
    logic r;
    logic [1:0] b;

    //          rst   btn    cyc lvl    p0 p1 r0 r1 l0 l1 ticks
    vecs[0] = '{1'b1, 2'b11,  3, 2'b00, 0, 0, 0, 0, 0, 0, 0};
    vecs[1] = '{1'b0, 2'b11, 40, 2'b00, 0, 0, 0, 0, 0, 0, 10};
    vecs[2] = '{1'b0, 2'b10, 20, 2'b01, 1, 0, 0, 0, 0, 0, 5};
    vecs[3] = '{1'b0, 2'b10, 30, 2'b01, 0, 0, 0, 0, 1, 0, 7};
    vecs[4] = '{1'b0, 2'b11, 20, 2'b00, 0, 0, 1, 0, 0, 0, 5};
    vecs[5] = '{1'b0, 2'b10, 10, 2'b00, 0, 0, 0, 0, 0, 0, 3};
    vecs[6] = '{1'b0, 2'b11, 30, 2'b00, 0, 0, 0, 0, 0, 0, 7};
    vecs[7] = '{1'b0, 2'b00, 20, 2'b11, 1, 1, 0, 0, 0, 0, 5};
    vecs[8] = '{1'b0, 2'b00, 20, 2'b11, 0, 0, 0, 0, 1, 1, 5};
    vecs[9] = '{1'b0, 2'b11, 20, 2'b00, 0, 0, 1, 1, 0, 0, 5};

    for (int v = 0; v < 10; v++) begin
      for (int ch = 0; ch < 2; ch++) begin
        cnt_p[ch] = 0; cnt_r[ch] = 0; cnt_l[ch] = 0;
      end
      cnt_t = 0;
      for (int c = 0; c < vecs[v].cycles; c++) step(vecs[v].rst, vecs[v].btn);
      check("vec_level", {30'd0, level_out}, {30'd0, vecs[v].lvl});
      check("vec_press0", cnt_p[0], vecs[v].p0);
      check("vec_press1", cnt_p[1], vecs[v].p1);
      check("vec_release0", cnt_r[0], vecs[v].r0);
      check("vec_release1", cnt_r[1], vecs[v].r1);
      check("vec_long0", cnt_l[0], vecs[v].l0);
      check("vec_long1", cnt_l[1], vecs[v].l1);
      check("vec_ticks", cnt_t, vecs[v].ticks);
      $display("vec %0d rst=%0b btn=%b cyc=%0d lvl=%b press=%0d/%0d rel=%0d/%0d long=%0d/%0d ticks=%0d",
               v, vecs[v].rst, vecs[v].btn, vecs[v].cycles, level_out, cnt_p[0], cnt_p[1],
               cnt_r[0], cnt_r[1], cnt_l[0], cnt_l[1], cnt_t);
    end

    // Reset after two agreeing ticks must force a full re-qualification.
    step(1'b1, 2'b11);
    step(1'b1, 2'b11);
    for (int c = 0; c < 9; c++) step(1'b0, 2'b10);
    check("pre_rst_level", {31'd0, level_out[0]}, 32'd0);
    step(1'b1, 2'b10);
    check("rst_outputs", {23'd0, level_out, press_pulse, release_pulse, long_pulse, sample_tick}, 32'd0);
    rise = 0;
    first_tick = 0;
    for (int i = 1; i <= 40 && rise == 0; i++) begin
      step(1'b0, 2'b10);
      if (sample_tick && first_tick == 0) first_tick = i;
      if (level_out[0]) begin
        rise = i;
        check("rise_press", {31'd0, press_pulse[0]}, 32'd1);
      end
    end
    check("first_tick", first_tick, 4);
    check("requal_latency", rise, 18);
    $display("requal first_tick=%0d rise=%0d", first_tick, rise);

    for (int seg = 0; seg < 120; seg++) begin
      r   = ($urandom_range(0, 39) == 0);
      b   = 2'($urandom_range(0, 3));
      len = r ? 1 : int'($urandom_range(1, 30));
      for (int c = 0; c < len; c++) step(r, b);
      $display("rand %0d rst=%0b btn=%b len=%0d lvl=%b", seg, r, b, len, level_out);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_array.md
Name: debounce_array

Overview:
Parametrised multi-channel push-button debouncer, the successor to the single-channel debouncer.
- Shared sample prescaler; per-channel 2-flop synchroniser and configurable-depth sample shift register.
- Polarity normalisation, so outputs are always "pressed = 1".
- Registered debounced level plus one-cycle press, release and long-press pulses, for direct use by front-panel control FSMs.

Parameters:
N_CH, 4, number of independent button channels (>=1)
SAMPLE_DIV, 500000, clk cycles per sample tick (>=1; 500000 = 10 ms at 50 MHz)
DEPTH, 4, consecutive agreeing samples required to change state (>=2)
ACTIVE_LOW, 1, 1 = raw input low means pressed; 0 = raw high means pressed
HOLD_TICKS, 100, sample ticks of continuous press before long_pulse fires (0 = long-press disabled)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
btn_in  in  N_CH  raw asynchronous button inputs
level_out  out  N_CH  debounced level, 1 = pressed
press_pulse  out  N_CH  one-cycle pulse on debounced 0->1
release_pulse  out  N_CH  one-cycle pulse on debounced 1->0
long_pulse  out  N_CH  one-cycle pulse when press has lasted HOLD_TICKS ticks
sample_tick  out  1  prescaler tick, exported for bench and other blocks

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high; all state is updated only on posedge clk.
- Values on rst: prescaler count = 0; sample_tick = 0; synchroniser flops = unpressed raw level (ACTIVE_LOW ? 1 : 0); shift registers = all 0 (normalised unpressed); level_out = 0; all pulses = 0; hold counters = 0.
- A rst asserted mid-operation aborts any pending transition. No pulse is emitted on reset entry or exit.
- Prescaler:
  - Counter width $clog2(SAMPLE_DIV) (min 1); counts 0..SAMPLE_DIV-1, then wraps to 0.
  - sample_tick is registered and high for exactly one cycle per wrap.
  - First tick occurs SAMPLE_DIV cycles after rst deasserts. SAMPLE_DIV=1 gives a tick every cycle.
- Synchroniser: 2 flops per channel. Normalised sample s = ACTIVE_LOW ? ~sync2 : sync2.
- Shift register (DEPTH bits per channel): on a cycle with sample_tick = 1, shift left and load s into bit 0; otherwise hold.
- Level, every clk:
  - All ones and level_out = 0: level_out <= 1 and press_pulse <= 1.
  - All zeros and level_out = 1: level_out <= 0 and release_pulse <= 1.
  - Otherwise: level_out holds and both pulses <= 0.
  - Pulses are therefore high in the same cycle level_out first shows the new value, for exactly one cycle.
- Latency: a clean, stable input change is reflected on level_out within 2 + DEPTH*SAMPLE_DIV + 2 cycles. It is never reflected before DEPTH ticks have sampled the new value.
- Glitch rejection: any input disturbance spanning fewer than DEPTH consecutive ticks never changes level_out.
- Long press:
  - Per-channel hold counter, width $clog2(HOLD_TICKS+1).
  - Cleared while level_out = 0. Increments on each sample_tick while level_out = 1. Saturates at HOLD_TICKS.
  - On the tick where the counter reaches HOLD_TICKS, long_pulse <= 1 for one cycle.
  - At most one long_pulse per press; a release followed by a new press re-arms it.
  - HOLD_TICKS = 0: long_pulse is constant 0.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses.
- No combinational path from btn_in to any output.

Decomposition:
- Package debounce_pkg holds:
  - localparam functions for counter widths (safe clog2 with minimum 1);
  - the normalised PRESSED/RELEASED constants.
- Sub-module debounce_channel contains one channel: synchroniser, shift register, level/pulse logic and hold counter. It takes sample_tick as an input.
- debounce_array contains the single shared prescaler and a generate loop over N_CH instances of debounce_channel.

Test Plan:
All scenarios use N_CH=2, SAMPLE_DIV=4, DEPTH=4, ACTIVE_LOW=1, HOLD_TICKS=3.
1. Reset, then btn_in=2'b11 for 40 cycles -> level_out=0, no pulses; sample_tick every 4th cycle, first at cycle 4 after rst release.
2. btn_in[0] driven 0 and held -> level_out[0] rises within 2+16+2 = 20 cycles; press_pulse[0] high exactly one cycle, coincident with the rise; channel 1 unchanged.
3. btn_in[0] low for 10 cycles (fewer than 4 ticks), then high -> level_out[0] stays 0, no pulses.
4. Continuing from scenario 2, hold btn_in[0]=0 -> long_pulse[0] once on the 3rd tick after the level rise; no further long_pulse while held. Then release -> release_pulse[0] one cycle, level_out[0]=0.
5. Both channels driven 0 in the same cycle -> level_out and press_pulse rise on both in the same cycle.
6. Assert rst for 1 cycle mid-transition (after 2 of 4 agreeing ticks) -> all outputs 0. After release, the full DEPTH-tick qualification is needed again before level_out rises.
